// File: rtl/master_control_if.sv
// Board-level link between the chip2chip master and the slave control:
// request/valid/data go out from the master, ack comes back from the slave.
interface master_control_if #(
  parameter int DATA_W = 3
);
  logic              request;
  logic              valid;
  logic [DATA_W-1:0] data_out;
  logic              ack;

  modport master (output request, output valid, output data_out, input ack);
  modport slave  (input request, input valid, input data_out, output ack);
endinterface

// File: rtl/master_control.sv
// Chip2chip master control: on a send pulse, raises request/valid/data to the
// slave, waits for its ack, holds valid for VALID_HOLD cycles, then releases.
module master_control #(
  parameter int DATA_W        = 3,
  parameter int NOTICE_CYCLES = 100_000_000,
  parameter int VALID_HOLD    = 4,
  parameter int ACK_TIMEOUT   = 300_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic [DATA_W-1:0] data_sw,
  master_control_if.master  link,
  output logic              notice,
  output logic              busy,
  output logic              timeout_err
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
  localparam int NOT_W = $clog2(NOTICE_CYCLES) + 1;
  localparam int HLD_W = $clog2(VALID_HOLD) + 1;

  typedef enum logic [1:0] {IDLE, REQ, ACKED, RELEASE} state_t;

  state_t            state_q, state_d;
  logic              ack_m, ack_s;
  logic [TMR_W-1:0]  timer;
  logic [HLD_W-1:0]  hold;
  logic [NOT_W-1:0]  notice_cnt, notice_cnt_d;
  logic [DATA_W-1:0] data_lat, data_d;
  logic              start, abort, req_d, valid_d;

  // ack crosses from the other chip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= link.ack;
      ack_s <= ack_m;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (send) begin
        start   = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        if (ack_s) begin
          state_d = ACKED;
        end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      ACKED:   if (hold == HLD_W'(VALID_HOLD - 1)) state_d = RELEASE;
      RELEASE: if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the transition edge.
    req_d   = (state_d == REQ);
    valid_d = (state_d == REQ) || (state_d == ACKED);
    data_d  = valid_d ? (start ? data_sw : data_lat) : '0;

    notice_cnt_d = notice_cnt;
    if (state_q == REQ && state_d == ACKED) begin
      notice_cnt_d = NOT_W'(NOTICE_CYCLES);
    end else if (notice_cnt != '0) begin
      notice_cnt_d = notice_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer         <= '0;
      hold          <= '0;
      notice_cnt    <= '0;
      data_lat      <= '0;
      link.request  <= 1'b0;
      link.valid    <= 1'b0;
      link.data_out <= '0;
      notice        <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      link.request  <= req_d;
      link.valid    <= valid_d;
      link.data_out <= data_d;
      notice_cnt    <= notice_cnt_d;
      notice        <= (notice_cnt_d != '0);
      busy          <= (state_d != IDLE);

      if (start) data_lat <= data_sw;

      if (start)      timeout_err <= 1'b0;
      else if (abort) timeout_err <= 1'b1;

      // Held at zero outside REQ, so it is cleared on entry; saturates at all-ones.
      if (state_q != REQ)  timer <= '0;
      else if (timer != '1) timer <= timer + 1'b1;

      if (state_q != ACKED) hold <= '0;
      else if (hold != '1)  hold <= hold + 1'b1;
    end
  end

endmodule

// File: tb/tb_master_control.sv
// Directed bench for master_control: reset, normal transfer, busy-ignore,
// timeout, ack/timeout race and loopback against a small slave model.
module tb_master_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send;
  logic [2:0] data_sw;
  logic       notice, busy, timeout_err;
  logic       ack_drv, loop_en;
  int         checks = 0;
  int         errors = 0;

  master_control_if #(.DATA_W(3)) link ();

  master_control #(
    .DATA_W(3),
    .NOTICE_CYCLES(8),
    .VALID_HOLD(4),
    .ACK_TIMEOUT(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .send(send),
    .data_sw(data_sw),
    .link(link),
    .notice(notice),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Slave model: sees request, waits a few cycles, acks, captures data while
  // valid, drops ack once valid falls.
  typedef enum logic [1:0] {S_WAIT, S_DELAY, S_ACK} sl_t;
  sl_t        sl_state;
  logic [1:0] sl_cnt;
  logic       s_ack;
  logic [2:0] s_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_state <= S_WAIT;
      sl_cnt   <= 2'd0;
      s_ack    <= 1'b0;
      s_data   <= 3'd0;
    end else begin
      case (sl_state)
        S_WAIT: if (link.request) begin
          sl_cnt   <= 2'd0;
          sl_state <= S_DELAY;
        end
        S_DELAY: begin
          sl_cnt <= sl_cnt + 2'd1;
          if (sl_cnt == 2'd2) begin
            s_ack    <= 1'b1;
            sl_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (link.valid) s_data <= link.data_out;
          else begin
            s_ack    <= 1'b0;
            sl_state <= S_WAIT;
          end
        end
        default: sl_state <= S_WAIT;
      endcase
    end
  end

  assign link.ack = loop_en ? s_ack : ack_drv;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 8'(busy), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; send = 1'b0; data_sw = 3'd0; ack_drv = 1'b0; loop_en = 1'b0;
    step(2);
    chk("rst_request", 8'(link.request), 8'd0);
    chk("rst_valid",   8'(link.valid),   8'd0);
    chk("rst_data",    8'(link.data_out), 8'd0);
    chk("rst_notice",  8'(notice), 8'd0);
    chk("rst_busy",    8'(busy), 8'd0);
    chk("rst_terr",    8'(timeout_err), 8'd0);
    rst_n = 1'b1;
    step(1);

    // Normal transfer with busy-ignore sends
    data_sw = 3'b101; send = 1'b1;
    step(1);
    send = 1'b0;
    chk("n_req_on",   8'(link.request), 8'd1);
    chk("n_valid_on", 8'(link.valid),   8'd1);
    chk("n_data",     8'(link.data_out), 8'h5);
    chk("n_busy",     8'(busy), 8'd1);
    data_sw = 3'b010;
    step(4);
    send = 1'b1;
    step(1);
    send = 1'b0;
    chk("busy_ign_req", 8'(link.data_out), 8'h5);
    step(4);
    ack_drv = 1'b1;
    step(2);
    chk("n_req_pre_acks", 8'(link.request), 8'd1);
    step(1);
    chk("n_req_off",    8'(link.request), 8'd0);
    chk("n_valid_hold", 8'(link.valid), 8'd1);
    chk("n_notice_on",  8'(notice), 8'd1);
    chk("n_data_hold",  8'(link.data_out), 8'h5);
    step(1);
    send = 1'b1;
    step(1);
    send = 1'b0;
    step(1);
    chk("n_valid_last", 8'(link.valid), 8'd1);
    chk("busy_ign_ack", 8'(link.data_out), 8'h5);
    step(1);
    chk("n_valid_off",  8'(link.valid), 8'd0);
    chk("n_data_off",   8'(link.data_out), 8'd0);
    chk("n_busy_rel",   8'(busy), 8'd1);
    step(1);
    ack_drv = 1'b0;
    step(2);
    chk("n_notice_last", 8'(notice), 8'd1);
    chk("n_busy_rel2",   8'(busy), 8'd1);
    step(1);
    chk("n_notice_off", 8'(notice), 8'd0);
    chk("n_idle",       8'(busy), 8'd0);
    step(3);
    chk("one_xfer_busy", 8'(busy), 8'd0);
    chk("one_xfer_req",  8'(link.request), 8'd0);

    // Timeout: 32 cycles in REQ, send coinciding with abort ignored
    data_sw = 3'b011; send = 1'b1;
    step(1);
    send = 1'b0;
    chk("t_req_on", 8'(link.request), 8'd1);
    step(31);
    chk("t_req_last", 8'(link.request), 8'd1);
    chk("t_terr_pre", 8'(timeout_err), 8'd0);
    send = 1'b1;
    step(1);
    send = 1'b0;
    chk("t_req_off", 8'(link.request), 8'd0);
    chk("t_valid",   8'(link.valid), 8'd0);
    chk("t_data",    8'(link.data_out), 8'd0);
    chk("t_terr",    8'(timeout_err), 8'd1);
    chk("t_busy",    8'(busy), 8'd0);
    step(1);
    chk("abort_send_ign", 8'(busy), 8'd0);
    chk("t_terr_sticky",  8'(timeout_err), 8'd1);

    // Race: ack_s rises while timer==31 -> ACKED wins
    data_sw = 3'b100; send = 1'b1;
    step(1);
    send = 1'b0;
    chk("r_terr_clr", 8'(timeout_err), 8'd0);
    chk("r_req_on",   8'(link.request), 8'd1);
    step(29);
    ack_drv = 1'b1;
    step(2);
    chk("r_req_last", 8'(link.request), 8'd1);
    step(1);
    chk("r_req_off", 8'(link.request), 8'd0);
    chk("r_valid",   8'(link.valid), 8'd1);
    chk("r_terr",    8'(timeout_err), 8'd0);
    chk("r_busy",    8'(busy), 8'd1);
    chk("r_data",    8'(link.data_out), 8'h4);
    ack_drv = 1'b0;
    wait_idle("r_idle");

    // Asynchronous reset mid-REQ
    data_sw = 3'b111; send = 1'b1;
    step(1);
    send = 1'b0;
    step(2);
    chk("a_req_pre", 8'(link.request), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_request", 8'(link.request), 8'd0);
    chk("a_valid",   8'(link.valid), 8'd0);
    chk("a_data",    8'(link.data_out), 8'd0);
    chk("a_notice",  8'(notice), 8'd0);
    chk("a_busy",    8'(busy), 8'd0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("a_no_resume", 8'(busy), 8'd0);

    // Loopback against slave model, back-to-back
    loop_en = 1'b1;
    data_sw = 3'b110; send = 1'b1;
    step(1);
    send = 1'b0;
    wait_idle("l1_idle");
    chk("l1_sdata", 8'(s_data), 8'h6);
    chk("l1_sstate", 8'(sl_state), 8'(S_WAIT));
    chk("l1_terr", 8'(timeout_err), 8'd0);
    data_sw = 3'b011; send = 1'b1;
    step(1);
    send = 1'b0;
    wait_idle("l2_idle");
    chk("l2_sdata", 8'(s_data), 8'h3);
    chk("l2_sstate", 8'(sl_state), 8'(S_WAIT));
    chk("l2_terr", 8'(timeout_err), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
